// File: rtl/axi_reg_slice_pkg.sv
// rtl/axi_reg_slice_pkg.sv - mode constants and two-entry state encoding for the register slice
package axi_reg_slice_pkg;

  localparam int RS_BYPASS = 0;
  localparam int RS_FWD    = 1;
  localparam int RS_REV    = 2;
  localparam int RS_FULL   = 3;

  // Bit 0 of the encoding doubles as the downstream valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b10,
    ST_ONE   = 2'b11,
    ST_FULL  = 2'b01
  } full_state_t;

  function automatic logic [1:0] state_level(input full_state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi_reg_slice_cfg_if.sv
// rtl/axi_reg_slice_cfg_if.sv - valid/ready payload channel with master/slave views
interface axi_reg_slice_cfg_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/axi_reg_slice_full_core.sv
// rtl/axi_reg_slice_full_core.sv - two-entry fully registered slice state machine
module axi_reg_slice_full_core
  import axi_reg_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            level
);

  full_state_t           state;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] p1;
  logic [DATA_WIDTH-1:0] p2;
  logic                  take;

  assign take = s_valid & rdy;

  // State, registered ready and the two payload slots; p1 always feeds the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      rdy   <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          rdy <= 1'b1;
          if (take) begin
            p1    <= s_data;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (take && m_ready) begin
            p1 <= s_data;
          end else if (take) begin
            p2    <= s_data;
            state <= ST_FULL;
            rdy   <= 1'b0;
          end else if (m_ready) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (m_ready) begin
            p1    <= p2;
            state <= ST_ONE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= ST_EMPTY;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = rdy;
  assign m_valid = state[0];
  assign m_data  = p1;
  assign level   = state_level(state);

endmodule

// File: rtl/axi_reg_slice_cfg.sv
// rtl/axi_reg_slice_cfg.sv - mode-selectable valid/ready register slice; optional checker under AXI_REG_SLICE_PROTO_CHECK_EN
module axi_reg_slice_cfg
  import axi_reg_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = RS_FULL
) (
  input  logic                clk,
  input  logic                reset,
  axi_reg_slice_cfg_if.slave  s,
  axi_reg_slice_cfg_if.master m,
  output logic [1:0]          level,
  output logic                protocol_err
);

  logic                  s_ready_i;
  logic                  m_valid_i;
  logic [DATA_WIDTH-1:0] m_data_i;
  logic [1:0]            level_i;

  if (MODE == RS_BYPASS) begin : g_bypass
    assign s_ready_i = m.ready;
    assign m_valid_i = s.valid;
    assign m_data_i  = s.data;
    assign level_i   = 2'd0;
  end else if (MODE == RS_FWD) begin : g_fwd
    logic                  run;
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;

    // run holds ready low for the first cycle after reset release.
    always_ff @(posedge clk) begin
      if (reset) begin
        run <= 1'b0;
        vld <= 1'b0;
      end else begin
        run <= 1'b1;
        if (s.valid && s_ready_i) begin
          vld <= 1'b1;
        end else if (m.ready) begin
          vld <= 1'b0;
        end
      end
    end

    // Payload register loads on every accepted beat.
    always_ff @(posedge clk) begin
      if (s.valid && s_ready_i) begin
        dat <= s.data;
      end
    end

    assign s_ready_i = run & ~reset & (~vld | m.ready);
    assign m_valid_i = vld;
    assign m_data_i  = dat;
    assign level_i   = {1'b0, vld};
  end else if (MODE == RS_REV) begin : g_rev
    logic                  rdy;
    logic                  skid_vld;
    logic                  skid_nxt;
    logic                  capture;
    logic [DATA_WIDTH-1:0] skid_dat;

    assign capture = ~skid_vld & s.valid & rdy & ~m.ready;

    // Next skid occupancy: drains on downstream ready, fills on a stalled accept.
    always_comb begin
      skid_nxt = skid_vld;
      if (skid_vld) begin
        if (m.ready) begin
          skid_nxt = 1'b0;
        end
      end else if (capture) begin
        skid_nxt = 1'b1;
      end
    end

    // Occupancy and registered ready; ready is simply the inverse of next occupancy.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdy      <= 1'b0;
        skid_vld <= 1'b0;
      end else begin
        rdy      <= ~skid_nxt;
        skid_vld <= skid_nxt;
      end
    end

    // Skid payload captures the beat the downstream could not take.
    always_ff @(posedge clk) begin
      if (capture) begin
        skid_dat <= s.data;
      end
    end

    assign s_ready_i = rdy;
    assign m_valid_i = skid_vld | (s.valid & rdy);
    assign m_data_i  = skid_vld ? skid_dat : s.data;
    assign level_i   = {1'b0, skid_vld};
  end else begin : g_full
    axi_reg_slice_full_core #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s.data),
      .s_valid (s.valid),
      .s_ready (s_ready_i),
      .m_data  (m_data_i),
      .m_valid (m_valid_i),
      .m_ready (m.ready),
      .level   (level_i)
    );
  end

  assign s.ready = s_ready_i;
  assign m.valid = m_valid_i;
  assign m.data  = m_data_i;
  assign level   = level_i;

`ifdef AXI_REG_SLICE_PROTO_CHECK_EN
  logic                  prev_stall;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  err;

  // Sticky flag: a stalled upstream beat must stay valid with stable payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_stall <= s.valid & ~s_ready_i;
      if (prev_stall && (!s.valid || (s.data != prev_data))) begin
        err <= 1'b1;
      end
    end
  end

  // Previous payload for the stability comparison.
  always_ff @(posedge clk) begin
    prev_data <= s.data;
  end

  assign protocol_err = err;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_reg_slice_cfg.sv
// tb/tb_axi_reg_slice_cfg.sv - directed and scoreboard checks of all four slice modes
module tb_axi_reg_slice_cfg;

`ifdef AXI_REG_SLICE_PROTO_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [1:0] level0, level1, level2, level3;
  logic perr0, perr1, perr2, perr3;
  int total;
  int bad;

  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) s0 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) m0 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) s1 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) m1 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) s2 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) m2 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) s3 ();
  axi_reg_slice_cfg_if #(.DATA_WIDTH(8)) m3 ();

  axi_reg_slice_cfg #(.DATA_WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .s(s0), .m(m0), .level(level0), .protocol_err(perr0));
  axi_reg_slice_cfg #(.DATA_WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .s(s1), .m(m1), .level(level1), .protocol_err(perr1));
  axi_reg_slice_cfg #(.DATA_WIDTH(8), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .s(s2), .m(m2), .level(level2), .protocol_err(perr2));
  axi_reg_slice_cfg #(.DATA_WIDTH(8), .MODE(3)) u3 (
    .clk(clk), .reset(reset), .s(s3), .m(m3), .level(level3), .protocol_err(perr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    s0.valid = 0; s0.data = 0; m0.ready = 0;
    s1.valid = 0; s1.data = 0; m1.ready = 0;
    s2.valid = 0; s2.data = 0; m2.ready = 0;
    s3.valid = 0; s3.data = 0; m3.ready = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1; idle_all(); m0.ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({m3.valid, m2.valid, m1.valid} !== 3'b000) begin bad++;
      $display("FAIL reset_mvalid got %b want 000", {m3.valid, m2.valid, m1.valid}); end
    total++; if ({s3.ready, s2.ready, s1.ready} !== 3'b000) begin bad++;
      $display("FAIL reset_sready got %b want 000", {s3.ready, s2.ready, s1.ready}); end
    total++; if ({level3, level2, level1, level0} !== 8'h00) begin bad++;
      $display("FAIL reset_level got %h want 00", {level3, level2, level1, level0}); end
    total++; if ({perr3, perr2, perr1, perr0} !== 4'b0000) begin bad++;
      $display("FAIL reset_perr got %b want 0000", {perr3, perr2, perr1, perr0}); end
    total++; if (s0.ready !== 1'b1) begin bad++;
      $display("FAIL reset_bypass_ready got %b want 1", s0.ready); end
    @(posedge clk); #1;
    reset = 0; m0.ready = 0;
    @(negedge clk);
    total++; if ({s3.ready, s2.ready, s1.ready} !== 3'b000) begin bad++;
      $display("FAIL release_sready_first got %b want 000", {s3.ready, s2.ready, s1.ready}); end
    total++; if ({m3.valid, m2.valid, m1.valid} !== 3'b000) begin bad++;
      $display("FAIL release_mvalid_first got %b want 000", {m3.valid, m2.valid, m1.valid}); end
    @(negedge clk);
    total++; if ({s3.ready, s2.ready, s1.ready} !== 3'b111) begin bad++;
      $display("FAIL release_sready_next got %b want 111", {s3.ready, s2.ready, s1.ready}); end
  endtask

  task automatic test_full_stream();
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk); #1;
      m3.ready = 1;
      s3.valid = (c < 10);
      s3.data = (c < 10) ? 8'(c + 1) : 8'h00;
      @(negedge clk);
      if (c < 10) begin
        total++; if (s3.ready !== 1'b1) begin bad++;
          $display("FAIL stream_sready c=%0d got %b want 1", c, s3.ready); end
      end
      if (c == 0 || c == 11) begin
        total++; if (m3.valid !== 1'b0 || level3 !== 2'd0) begin bad++;
          $display("FAIL stream_idle c=%0d got v=%b lvl=%0d want v=0 lvl=0", c, m3.valid, level3); end
      end else begin
        total++; if (m3.valid !== 1'b1 || m3.data !== 8'(c) || level3 !== 2'd1) begin bad++;
          $display("FAIL stream_out c=%0d got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
                   c, m3.valid, m3.data, level3, 8'(c)); end
      end
    end
  endtask

  task automatic test_full_backpressure();
    logic [7:0] din [0:7]    = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00};
    logic       vin [0:7]    = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic       rin [0:7]    = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic       exp_sr [0:7] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic       exp_mv [0:7] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] exp_md [0:7] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0] exp_lv [0:7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      s3.valid = vin[c]; s3.data = din[c]; m3.ready = rin[c];
      @(negedge clk);
      total++;
      if (s3.ready !== exp_sr[c] || m3.valid !== exp_mv[c] || level3 !== exp_lv[c] ||
          (exp_mv[c] && m3.data !== exp_md[c])) begin
        bad++;
        $display("FAIL backpressure c=%0d got sr=%b mv=%b md=%h lvl=%0d want sr=%b mv=%b md=%h lvl=%0d",
                 c, s3.ready, m3.valid, m3.data, level3, exp_sr[c], exp_mv[c], exp_md[c], exp_lv[c]);
      end
    end
  endtask

  task automatic test_rev_skid();
    logic [7:0] din [0:4]    = '{8'hC3, 8'h3C, 8'h3C, 8'h3C, 8'h00};
    logic       vin [0:4]    = '{1, 1, 1, 1, 0};
    logic       rin [0:4]    = '{0, 0, 1, 1, 1};
    logic       exp_sr [0:4] = '{1, 0, 0, 1, 1};
    logic       exp_mv [0:4] = '{1, 1, 1, 1, 0};
    logic [7:0] exp_md [0:4] = '{8'hC3, 8'hC3, 8'hC3, 8'h3C, 8'h00};
    logic [1:0] exp_lv [0:4] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      s2.valid = vin[c]; s2.data = din[c]; m2.ready = rin[c];
      @(negedge clk);
      total++;
      if (s2.ready !== exp_sr[c] || m2.valid !== exp_mv[c] || level2 !== exp_lv[c] ||
          (exp_mv[c] && m2.data !== exp_md[c])) begin
        bad++;
        $display("FAIL rev_skid c=%0d got sr=%b mv=%b md=%h lvl=%0d want sr=%b mv=%b md=%h lvl=%0d",
                 c, s2.ready, m2.valid, m2.data, level2, exp_sr[c], exp_mv[c], exp_md[c], exp_lv[c]);
      end
    end
  endtask

  task automatic test_rev_toggle();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic hold;
    logic r0;
    int sent;
    hold = 0; sent = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      m2.ready = c[0];
      if (!hold) begin
        s2.valid = (c < 280) && ($urandom_range(3) != 0);
        s2.data = 8'($urandom);
      end
      @(negedge clk);
      r0 = s2.ready;
      m2.ready = ~m2.ready; #1;
      total++; if (s2.ready !== r0) begin bad++;
        $display("FAIL rev_ready_comb c=%0d got %b want %b", c, s2.ready, r0); end
      m2.ready = ~m2.ready; #1;
      if (s2.valid && s2.ready) begin q.push_back(s2.data); sent++; end
      if (m2.valid && m2.ready) begin
        total++;
        if (q.size() == 0) begin bad++;
          $display("FAIL rev_order c=%0d got d=%h want no beat", c, m2.data);
        end else begin
          exp = q.pop_front();
          if (m2.data !== exp) begin bad++;
            $display("FAIL rev_order c=%0d got d=%h want %h", c, m2.data, exp); end
        end
      end
      hold = s2.valid & ~s2.ready;
    end
    total++; if (q.size() != 0 || sent < 50) begin bad++;
      $display("FAIL rev_drain got left=%0d sent=%0d want left=0 sent>=50", q.size(), sent); end
  endtask

  task automatic test_random_fwd_bypass();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp;
    logic hold0, hold1;
    int sent0, sent1, got0, got1;
    hold0 = 0; hold1 = 0; sent0 = 0; sent1 = 0; got0 = 0; got1 = 0;
    for (int c = 0; c < 20000 && (got0 < 1000 || got1 < 1000); c++) begin
      @(posedge clk); #1;
      m0.ready = 1'($urandom_range(1));
      m1.ready = 1'($urandom_range(1));
      if (!hold0) begin
        s0.valid = (sent0 < 1000) && ($urandom_range(1) == 1);
        s0.data = 8'($urandom);
      end
      if (!hold1) begin
        s1.valid = (sent1 < 1000) && ($urandom_range(1) == 1);
        s1.data = 8'($urandom);
      end
      @(negedge clk);
      if (s0.valid && s0.ready) begin q0.push_back(s0.data); sent0++; end
      if (s1.valid && s1.ready) begin q1.push_back(s1.data); sent1++; end
      if (m0.valid && m0.ready) begin
        total++; got0++;
        exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
        if (m0.data !== exp) begin bad++;
          $display("FAIL bypass_sb beat=%0d got %h want %h", got0, m0.data, exp); end
      end
      if (m1.valid && m1.ready) begin
        total++; got1++;
        exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
        if (m1.data !== exp) begin bad++;
          $display("FAIL fwd_sb beat=%0d got %h want %h", got1, m1.data, exp); end
      end
      hold0 = s0.valid & ~s0.ready;
      hold1 = s1.valid & ~s1.ready;
    end
    total++; if (got0 != 1000 || got1 != 1000) begin bad++;
      $display("FAIL random_count got bypass=%0d fwd=%0d want 1000 each", got0, got1); end
    @(posedge clk); #1;
    s0.valid = 0; s1.valid = 0; m0.ready = 1; m1.ready = 1;
    @(negedge clk);
    total++; if (level1 !== 2'd0 || m1.valid !== 1'b0) begin bad++;
      $display("FAIL fwd_empty got lvl=%0d v=%b want lvl=0 v=0", level1, m1.valid); end
  endtask

  task automatic test_reset_full();
    @(posedge clk); #1; idle_all(); s3.valid = 1; s3.data = 8'h44;
    @(posedge clk); #1; s3.data = 8'h55;
    @(posedge clk); #1; s3.data = 8'h66;
    @(negedge clk);
    total++; if (level3 !== 2'd2 || s3.ready !== 1'b0) begin bad++;
      $display("FAIL rstfull_fill got lvl=%0d sr=%b want lvl=2 sr=0", level3, s3.ready); end
    @(posedge clk); #1; reset = 1; s3.valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (m3.valid !== 1'b0 || s3.ready !== 1'b0 || level3 !== 2'd0 || perr3 !== 1'b0) begin bad++;
      $display("FAIL rstfull_clear got mv=%b sr=%b lvl=%0d pe=%b want 0 0 0 0", m3.valid, s3.ready, level3, perr3); end
    @(posedge clk); #1; reset = 0; m3.ready = 1;
    @(negedge clk);
    total++; if (s3.ready !== 1'b0 || m3.valid !== 1'b0) begin bad++;
      $display("FAIL rstfull_release got sr=%b mv=%b want sr=0 mv=0", s3.ready, m3.valid); end
    @(negedge clk);
    total++; if (s3.ready !== 1'b1) begin bad++;
      $display("FAIL rstfull_ready got %b want 1", s3.ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (m3.valid !== 1'b0 || level3 !== 2'd0) begin bad++;
        $display("FAIL rstfull_stale c=%0d got mv=%b lvl=%0d want mv=0 lvl=0", c, m3.valid, level3); end
    end
  endtask

  task automatic test_proto();
    logic [7:0] din [0:8] = '{8'h01, 8'h02, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    @(posedge clk); #1; idle_all();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      s3.valid = 1; s3.data = din[c];
      @(negedge clk);
      total++;
      if (c < 5) begin
        if (perr3 !== 1'b0) begin bad++;
          $display("FAIL proto_early c=%0d got %b want 0", c, perr3); end
      end else begin
        if (perr3 !== EXP_ERR) begin bad++;
          $display("FAIL proto_sticky c=%0d got %b want %b", c, perr3, EXP_ERR); end
      end
    end
    total++; if ({perr2, perr1, perr0} !== 3'b000) begin bad++;
      $display("FAIL proto_others got %b want 000", {perr2, perr1, perr0}); end
    @(posedge clk); #1; reset = 1; idle_all();
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    total++; if (perr3 !== 1'b0) begin bad++;
      $display("FAIL proto_reset got %b want 0", perr3); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1;
    idle_all();
    test_reset();
    test_full_stream();
    test_full_backpressure();
    test_rev_skid();
    test_rev_toggle();
    test_random_fwd_bypass();
    test_reset_full();
    test_proto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
